// File: rtl/serial_subtractor_23bit.sv
// -----------------------------------------------------------------------------
// serial_subtractor_23bit
//
// Bit-serial unsigned subtractor: diff = (a - b) mod 2^WIDTH, borrow_out = a < b.
// Processes BITS_PER_CYCLE bits per clock, LSB first, through a borrow
// flip-flop. Operands are accepted with a valid/ready handshake and the result
// is offered with a second valid/ready handshake.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   in_valid    operands a/b valid
//   in_ready    block can accept operands (high only in IDLE)
//   a, b        minuend / subtrahend, unsigned, WIDTH bits
//   out_valid   diff/borrow_out valid (high only in DONE)
//   out_ready   consumer accepts the result
//   diff        (a - b) mod 2^WIDTH
//   borrow_out  1 when a < b
//   busy        high in RUN or DONE
// -----------------------------------------------------------------------------
module serial_subtractor_23bit #(
  parameter int WIDTH          = 23,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             busy
);

  localparam int NCHUNK = (WIDTH + BITS_PER_CYCLE - 1) / BITS_PER_CYCLE;
  // Operands and result are padded up to a whole number of chunks. The pad
  // bits of the operands are zero, so the borrow simply ripples through them
  // and the final borrow is still the borrow out of bit WIDTH-1.
  localparam int PW     = NCHUNK * BITS_PER_CYCLE;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                    state_q;
  logic [PW-1:0]             a_q, b_q;
  logic [PW-1:0]             res_q, res_d;
  logic [CW-1:0]             cnt_q;
  logic                      borrow_q;
  logic                      borrow_out_q;
  logic                      in_ready_q, out_valid_q, busy_q;

  logic [BITS_PER_CYCLE-1:0] chunk_diff;
  logic                      borrow_d;

  // One chunk of subtraction. The (BITS_PER_CYCLE+1)-bit difference is
  // negative exactly when a borrow leaves this chunk, so its top bit is the
  // next borrow.
  always_comb begin
    {borrow_d, chunk_diff} = {1'b0, a_q[BITS_PER_CYCLE-1:0]}
                           - {1'b0, b_q[BITS_PER_CYCLE-1:0]}
                           - {{BITS_PER_CYCLE{1'b0}}, borrow_q};
  end

  // Operands shift right so the current chunk is always in the low bits; the
  // result shifts in from the top, so after NCHUNK steps chunk 0 sits at bit 0.
  if (NCHUNK == 1) begin : g_single_chunk
    assign res_d = chunk_diff;
  end else begin : g_multi_chunk
    assign res_d = {chunk_diff, res_q[PW-1:BITS_PER_CYCLE]};
  end

  // NOTE: state is updated with non-blocking assignments so every register in
  // this block samples the values from before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      cnt_q        <= '0;
      borrow_q     <= 1'b0;
      borrow_out_q <= 1'b0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // in_ready_q is always high here, so in_valid alone completes the
          // input handshake.
          if (in_valid) begin
            a_q        <= PW'(a);
            b_q        <= PW'(b);
            borrow_q   <= 1'b0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= RUN;
          end
        end

        RUN: begin
          a_q      <= a_q >> BITS_PER_CYCLE;
          b_q      <= b_q >> BITS_PER_CYCLE;
          res_q    <= res_d;
          borrow_q <= borrow_d;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == LAST_CHUNK) begin
            borrow_out_q <= borrow_d;
            out_valid_q  <= 1'b1;
            state_q      <= DONE;
          end
        end

        DONE: begin
          // in_ready rises only on the edge after the output handshake, so an
          // in_valid presented during the handshake cycle is not taken.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign diff       = res_q[WIDTH-1:0];
  assign borrow_out = borrow_out_q;

endmodule
